// File: rtl/awgen_pkg.sv
// Shared AXI AW constants, FSM encoding and sizing helper for the AW address generator.
package awgen_pkg;

   localparam logic [1:0] AXBURST_INCR = 2'b01;
   localparam logic [3:0] AXCACHE_DEF  = 4'b0011;
   localparam logic       AXLOCK_DEF   = 1'b0;
   localparam logic [2:0] AXPROT_DEF   = 3'h0;
   localparam logic [3:0] AXQOS_DEF    = 4'h0;
   localparam logic [3:0] AXREGION_DEF = 4'h0;

   localparam int unsigned AXLEN_W     = 8;
   // Burst beat count 1..256 needs one bit more than awlen
   localparam int unsigned BEATS_W     = 9;
   localparam int unsigned BURST_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      ISSUE = 2'd2,
      DONE  = 2'd3
   } awgen_state_e;

   // Ceiling log2 for elaboration-time sizing
   function automatic int unsigned log2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = 32'(i) + 32'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/awgen_burst_calc.sv
// Combinational burst sizing: beats = min(beats remaining, MAX_BURST, beats left before the boundary line).
module awgen_burst_calc
   import awgen_pkg::*;
#(
   parameter int unsigned BR_W      = 31,
   parameter int unsigned BND_W     = 12,
   parameter int unsigned SIZE_W    = 2,
   parameter int unsigned MAX_BURST = 256
) (
   input  logic [BR_W-1:0]    i_beats_rem,
   input  logic [BND_W-1:0]   i_addr_lo,
   output logic [BEATS_W-1:0] o_beats_c
);

   localparam int unsigned CW0        = (BR_W > BND_W + 1) ? BR_W : BND_W + 1;
   localparam int unsigned CW         = (CW0 > BEATS_W) ? CW0 : BEATS_W;
   localparam int unsigned LINE_BEATS = (32'd1 << BND_W) >> SIZE_W;

   logic [CW-1:0] w_rem;
   logic [CW-1:0] w_to_bnd;
   logic [CW-1:0] w_max;
   logic [CW-1:0] w_min_a;
   logic [CW-1:0] w_min;

   // Three-way minimum evaluated at a width that holds every operand
   always_comb begin
      w_rem     = CW'(i_beats_rem);
      w_to_bnd  = CW'(LINE_BEATS) - CW'(i_addr_lo >> SIZE_W);
      w_max     = CW'(MAX_BURST);
      w_min_a   = (w_rem < w_max) ? w_rem : w_max;
      w_min     = (w_min_a < w_to_bnd) ? w_min_a : w_to_bnd;
      o_beats_c = BEATS_W'(w_min);
   end

endmodule

// File: rtl/axi_awaddr_gen.sv
// AXI4 write-address generator: splits {addr, byte length} commands into INCR bursts
// limited by MAX_BURST beats and BOUNDARY-byte lines.
// Optional feature macro: AWGEN_ABORT_EN (abort input honoured; otherwise ignored, aborted = 0).
module axi_awaddr_gen
   import awgen_pkg::*;
#(
   parameter int unsigned ADDR_W     = 49,
   parameter int unsigned LEN_W      = 32,
   parameter int unsigned DATA_BYTES = 4,
   parameter int unsigned MAX_BURST  = 256,
   parameter int unsigned BOUNDARY   = 4096
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [ADDR_W-1:0]      cmd_addr,
   input  logic [LEN_W-1:0]       cmd_len,
   input  logic                   abort,
   output logic                   done,
   output logic                   aborted,
   output logic [BURST_CNT_W-1:0] burst_cnt,
   output logic [ADDR_W-1:0]      m_awaddr,
   output logic [AXLEN_W-1:0]     m_awlen,
   output logic [2:0]             m_awsize,
   output logic [1:0]             m_awburst,
   output logic [3:0]             m_awcache,
   output logic                   m_awlock,
   output logic [2:0]             m_awprot,
   output logic [3:0]             m_awqos,
   output logic [3:0]             m_awregion,
   output logic                   m_awvalid,
   input  logic                   m_awready
);

   localparam int unsigned SIZE_W = log2(DATA_BYTES);
   localparam int unsigned BND_W  = log2(BOUNDARY);
   localparam int unsigned BR_W   = LEN_W - SIZE_W + 1;

   awgen_state_e           r_state, w_state_nxt;
   logic [ADDR_W-1:0]      r_addr, w_addr_nxt;
   logic [BR_W-1:0]        r_beats_rem, w_beats_rem_nxt;
   logic [ADDR_W-1:0]      r_awaddr, w_awaddr_nxt;
   logic [AXLEN_W-1:0]     r_awlen, w_awlen_nxt;
   logic                   r_awvalid, w_awvalid_nxt;
   logic                   r_cmd_ready, w_cmd_ready_nxt;
   logic                   r_done, w_done_nxt;
   logic                   r_aborted, w_aborted_nxt;
   logic                   r_abort_lat, w_abort_lat_nxt;
   logic [BURST_CNT_W-1:0] r_burst_cnt, w_burst_cnt_nxt;

   logic                   w_abort;
   logic                   w_accept;
   logic                   w_hs;
   logic [BR_W-1:0]        w_cmd_beats;
   logic [BEATS_W-1:0]     w_beats_c;
   logic [BEATS_W-1:0]     w_burst_beats;

`ifdef AWGEN_ABORT_EN
   assign w_abort = abort;
`else
   logic w_unused_abort;
   assign w_abort        = 1'b0;
   assign w_unused_abort = abort;
`endif

   assign w_accept      = cmd_valid & r_cmd_ready;
   assign w_hs          = r_awvalid & m_awready;
   assign w_cmd_beats   = BR_W'(cmd_len >> SIZE_W);
   assign w_burst_beats = BEATS_W'(r_awlen) + BEATS_W'(1);

   // Size of the next burst from the working address and remaining beats
   awgen_burst_calc #(
      .BR_W      (BR_W),
      .BND_W     (BND_W),
      .SIZE_W    (SIZE_W),
      .MAX_BURST (MAX_BURST)
   ) u_burst_calc (
      .i_beats_rem (r_beats_rem),
      .i_addr_lo   (r_addr[BND_W-1:0]),
      .o_beats_c   (w_beats_c)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state, datapath and registered-output decode.
   // Every handshake returns through CALC, which also resolves completion/abort;
   // this gives the fixed one-cycle gap between bursts and before done.
   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_addr;
      w_beats_rem_nxt = r_beats_rem;
      w_awaddr_nxt    = r_awaddr;
      w_awlen_nxt     = r_awlen;
      w_burst_cnt_nxt = r_burst_cnt;
      w_abort_lat_nxt = r_abort_lat;

      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_addr_nxt      = cmd_addr & ~ADDR_W'(DATA_BYTES - 1);
               w_beats_rem_nxt = w_cmd_beats;
               w_burst_cnt_nxt = '0;
               w_abort_lat_nxt = 1'b0;
               w_state_nxt     = (w_cmd_beats == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (w_abort || r_abort_lat || (r_beats_rem == '0)) begin
               w_state_nxt = DONE;
            end else begin
               w_awaddr_nxt = r_addr;
               w_awlen_nxt  = AXLEN_W'(w_beats_c - BEATS_W'(1));
               w_state_nxt  = ISSUE;
            end
         end
         ISSUE: begin
            if (w_hs) begin
               w_addr_nxt      = r_addr + (ADDR_W'(w_burst_beats) << SIZE_W);
               w_beats_rem_nxt = r_beats_rem - BR_W'(w_burst_beats);
               w_burst_cnt_nxt = r_burst_cnt + BURST_CNT_W'(1);
               w_state_nxt     = CALC;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      if (((r_state == CALC) || (r_state == ISSUE)) && w_abort) w_abort_lat_nxt = 1'b1;

      w_cmd_ready_nxt = (w_state_nxt == IDLE);
      w_awvalid_nxt   = (w_state_nxt == ISSUE);
      w_done_nxt      = (w_state_nxt == DONE);
      w_aborted_nxt   = (w_state_nxt == DONE) && w_abort_lat_nxt;
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_beats_rem <= '0;
         r_awaddr    <= '0;
         r_awlen     <= '0;
         r_awvalid   <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_done      <= 1'b0;
         r_aborted   <= 1'b0;
         r_abort_lat <= 1'b0;
         r_burst_cnt <= '0;
      end else begin
         r_addr      <= w_addr_nxt;
         r_beats_rem <= w_beats_rem_nxt;
         r_awaddr    <= w_awaddr_nxt;
         r_awlen     <= w_awlen_nxt;
         r_awvalid   <= w_awvalid_nxt;
         r_cmd_ready <= w_cmd_ready_nxt;
         r_done      <= w_done_nxt;
         r_aborted   <= w_aborted_nxt;
         r_abort_lat <= w_abort_lat_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
      end
   end

   assign cmd_ready  = r_cmd_ready;
   assign done       = r_done;
   assign aborted    = r_aborted;
   assign burst_cnt  = r_burst_cnt;
   assign m_awaddr   = r_awaddr;
   assign m_awlen    = r_awlen;
   assign m_awvalid  = r_awvalid;
   assign m_awsize   = 3'(SIZE_W);
   assign m_awburst  = AXBURST_INCR;
   assign m_awcache  = AXCACHE_DEF;
   assign m_awlock   = AXLOCK_DEF;
   assign m_awprot   = AXPROT_DEF;
   assign m_awqos    = AXQOS_DEF;
   assign m_awregion = AXREGION_DEF;

endmodule

// File: tb/tb_axi_awaddr_gen.sv
// Bench for axi_awaddr_gen: directed and random commands checked against a burst-list model.
module tb_axi_awaddr_gen;

   localparam int unsigned ADDR_W = 49;
   localparam int unsigned LEN_W  = 32;
   localparam longint unsigned M_DB   = 4;
   localparam longint unsigned M_MB   = 256;
   localparam longint unsigned M_BND  = 4096;
   localparam longint unsigned M_AMOD = 64'd1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic              abort = 1'b0;
   logic              done;
   logic              aborted;
   logic [15:0]       burst_cnt;
   logic [ADDR_W-1:0] m_awaddr;
   logic [7:0]        m_awlen;
   logic [2:0]        m_awsize;
   logic [1:0]        m_awburst;
   logic [3:0]        m_awcache;
   logic              m_awlock;
   logic [2:0]        m_awprot;
   logic [3:0]        m_awqos;
   logic [3:0]        m_awregion;
   logic              m_awvalid;
   logic              m_awready = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [7:0]        l;
   } burst_t;
   burst_t exp_q[$];

   always #5 clk = ~clk;

   axi_awaddr_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_len    (cmd_len),
      .abort      (abort),
      .done       (done),
      .aborted    (aborted),
      .burst_cnt  (burst_cnt),
      .m_awaddr   (m_awaddr),
      .m_awlen    (m_awlen),
      .m_awsize   (m_awsize),
      .m_awburst  (m_awburst),
      .m_awcache  (m_awcache),
      .m_awlock   (m_awlock),
      .m_awprot   (m_awprot),
      .m_awqos    (m_awqos),
      .m_awregion (m_awregion),
      .m_awvalid  (m_awvalid),
      .m_awready  (m_awready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected burst list: walk the byte range, cutting at 256 beats and 4 KiB lines
   task automatic build_model(input logic [ADDR_W-1:0] a0, input logic [LEN_W-1:0] len);
      longint unsigned a, rem, room, b;
      burst_t e;
      exp_q.delete();
      a   = 64'(a0);
      a   = a - (a % M_DB);
      rem = 64'(len) / M_DB;
      while (rem > 0) begin
         room = (M_BND - (a % M_BND)) / M_DB;
         b = rem;
         if (b > M_MB) b = M_MB;
         if (b > room) b = room;
         e.a = ADDR_W'(a);
         e.l = 8'(b - 1);
         exp_q.push_back(e);
         a   = (a + b * M_DB) % M_AMOD;
         rem = rem - b;
      end
   endtask

   // Issue one command and check every AW beat, timing, stability and completion
   task automatic run_cmd(input string nm, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                          input int rdy_pct, input int stall_first, input bit do_abort);
      int     cyc, nb, last_hs, hold, exp_n;
      bit     done_seen, prev_vld, prev_rdy, ab_sent, exp_ab, held;
      logic [ADDR_W-1:0] prev_addr;
      logic [7:0]        prev_len;
      burst_t e;
      build_model(a, len);
      exp_ab = 1'b0;
`ifdef AWGEN_ABORT_EN
      if (do_abort) begin
         while (exp_q.size() > 1) exp_q.delete(exp_q.size() - 1);
         exp_ab = 1'b1;
      end
`endif
      exp_n = exp_q.size();
      @(negedge clk);
      chk({nm, " cmd_ready idle"}, 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_addr = a; cmd_len = len; m_awready = 1'b0; abort = 1'b0;
      cyc = 0; nb = 0; last_hs = 0; hold = 0;
      done_seen = 0; prev_vld = 0; prev_rdy = 0; ab_sent = 0;
      prev_addr = '0; prev_len = '0;
      while (!done_seen && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         // Offers made while busy must be ignored
         cmd_valid = 1'($urandom_range(1));
         cmd_addr  = ADDR_W'({$urandom, $urandom});
         cmd_len   = $urandom;
         abort     = 1'b0;
         chk({nm, " cmd_ready busy"}, 64'(cmd_ready), 64'd0);
         held = prev_vld && !prev_rdy;
         if (held) begin
            chk({nm, " awvalid held"}, 64'(m_awvalid), 64'd1);
            chk({nm, " awaddr stable"}, 64'(m_awaddr), 64'(prev_addr));
            chk({nm, " awlen stable"}, 64'(m_awlen), 64'(prev_len));
         end
         if (m_awvalid && !held) begin
            chk({nm, " awvalid cycle"}, 64'(cyc), 64'((nb == 0) ? 2 : last_hs + 2));
            hold = 0;
         end
         if (m_awvalid) begin
            if (nb == 0 && hold < stall_first) m_awready = 1'b0;
            else m_awready = ($urandom_range(99) < rdy_pct);
            hold++;
            if (do_abort && !ab_sent) begin
               abort = 1'b1;
               ab_sent = 1'b1;
            end
            if (m_awready) begin
               if (exp_q.size() == 0) begin
                  chk({nm, " burst count"}, 64'(nb + 1), 64'(exp_n));
               end else begin
                  e = exp_q.pop_front();
                  chk({nm, " awaddr"}, 64'(m_awaddr), 64'(e.a));
                  chk({nm, " awlen"}, 64'(m_awlen), 64'(e.l));
               end
               nb++;
               last_hs = cyc;
            end
         end else begin
            m_awready = 1'($urandom_range(1));
         end
         prev_vld  = m_awvalid;
         prev_rdy  = m_awready;
         prev_addr = m_awaddr;
         prev_len  = m_awlen;
         if (done) begin
            done_seen = 1'b1;
            chk({nm, " done cycle"}, 64'(cyc), 64'((nb == 0) ? 1 : last_hs + 2));
            chk({nm, " burst_cnt"}, 64'(burst_cnt), 64'(exp_n));
            chk({nm, " bursts seen"}, 64'(nb), 64'(exp_n));
            chk({nm, " aborted"}, 64'(aborted), 64'(exp_ab));
            cmd_valid = 1'b0;
            m_awready = 1'b0;
         end
      end
      chk({nm, " done reached"}, 64'(done_seen), 64'd1);
      cmd_valid = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      chk({nm, " done single pulse"}, 64'(done), 64'd0);
      chk({nm, " cmd_ready after"}, 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      logic [ADDR_W-1:0] ra;
      logic [LEN_W-1:0]  rl;
      // Reset values while rst_n is held low
      #12;
      chk("rst cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst awvalid", 64'(m_awvalid), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst aborted", 64'(aborted), 64'd0);
      chk("rst burst_cnt", 64'(burst_cnt), 64'd0);
      chk("rst awaddr", 64'(m_awaddr), 64'd0);
      chk("rst awlen", 64'(m_awlen), 64'd0);
      chk("awsize", 64'(m_awsize), 64'd2);
      chk("awburst", 64'(m_awburst), 64'd1);
      chk("awcache", 64'(m_awcache), 64'd3);
      chk("aw misc", 64'({m_awlock, m_awprot, m_awqos, m_awregion}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_cmd("full256", 49'h0, 32'h400, 100, 0, 1'b0);
      run_cmd("bndsplit", 49'hFF0, 32'h20, 100, 0, 1'b0);
      run_cmd("multi", 49'h0, 32'h1004, 70, 0, 1'b0);
      run_cmd("stall10", 49'h100, 32'h40, 100, 10, 1'b0);
      run_cmd("len0", 49'h123, 32'h0, 100, 0, 1'b0);
      run_cmd("unalign", 49'h3, 32'h4, 100, 0, 1'b0);
      run_cmd("wrap", 49'h1_FFFF_FFFF_FFF0, 32'h20, 50, 0, 1'b0);
      run_cmd("abort", 49'h0, 32'h800, 100, 0, 1'b1);

      for (int i = 0; i < 12; i++) begin
         ra = ADDR_W'({$urandom, $urandom});
         if (i % 3 == 0) ra = ADDR_W'(M_BND - 64'($urandom_range(64)));
         rl = LEN_W'($urandom_range(32'h1800)) & ~LEN_W'(3);
         run_cmd("rand", ra, rl, 40 + 5 * i, (i % 4 == 1) ? 3 : 0, 1'b0);
      end

      // Asynchronous reset while a burst is waiting for awready
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = 49'h2000; cmd_len = 32'h400; m_awready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 10 && !m_awvalid; i++) @(negedge clk);
      chk("pre-reset awvalid", 64'(m_awvalid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst awvalid", 64'(m_awvalid), 64'd0);
      chk("async rst cmd_ready", 64'(cmd_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-rst cmd_ready", 64'(cmd_ready), 64'd1);
      chk("post-rst burst_cnt", 64'(burst_cnt), 64'd0);
      chk("post-rst done", 64'(done), 64'd0);
      run_cmd("recover", 49'hFFC, 32'h8, 100, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
